// File: rtl/iob_assim_sync_fifo_if.sv
// Handshake bundle for the asymmetric-width FIFO: write port, read port and fill level.
// master = producer/consumer side, slave = FIFO side.
interface iob_assim_sync_fifo_if #(
   parameter int W_DATA_W = 16,
   parameter int R_DATA_W = 8,
   parameter int ADDR_W   = 4
);
   logic                w_en;
   logic [W_DATA_W-1:0] w_data;
   logic                w_full;
   logic                r_en;
   logic [R_DATA_W-1:0] r_data;
   logic                r_empty;
   logic [ADDR_W:0]     level;

   modport master (
      output w_en, w_data, r_en,
      input  w_full, r_data, r_empty, level
   );

   modport slave (
      input  w_en, w_data, r_en,
      output w_full, r_data, r_empty, level
   );
endinterface

// File: rtl/iob_assim_sync_fifo.sv
// Single-clock FIFO bridging unequal write/read widths over an array of narrow entries.
// Latency: r_data registered 1 cycle after an accepted r_en; a write is readable the next cycle.
// Backpressure: w_full/r_empty gate w_en/r_en; rejected requests change nothing.
module iob_assim_sync_fifo #(
   parameter int W_DATA_W = 16,
   parameter int R_DATA_W = 8,
   parameter int ADDR_W   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   iob_assim_sync_fifo_if.slave fifo_if
);
   localparam int MIN_W   = (W_DATA_W < R_DATA_W) ? W_DATA_W : R_DATA_W;
   localparam int MAX_W   = (W_DATA_W < R_DATA_W) ? R_DATA_W : W_DATA_W;
   localparam int W_RATIO = W_DATA_W / MIN_W;
   localparam int R_RATIO = R_DATA_W / MIN_W;
   localparam int RATIO   = MAX_W / MIN_W;
   localparam int DEPTH   = 1 << ADDR_W;

   localparam logic [ADDR_W:0]   FULL_THR = (ADDR_W+1)'(DEPTH - W_RATIO);
   localparam logic [ADDR_W:0]   W_INC    = (ADDR_W+1)'(W_RATIO);
   localparam logic [ADDR_W:0]   R_DEC    = (ADDR_W+1)'(R_RATIO);
   localparam logic [ADDR_W-1:0] W_STEP   = ADDR_W'(W_RATIO);
   localparam logic [ADDR_W-1:0] R_STEP   = ADDR_W'(R_RATIO);

   generate
      if ((MAX_W % MIN_W) != 0 || (RATIO & (RATIO - 1)) != 0 || DEPTH < RATIO) begin : g_bad_params
         $error("iob_assim_sync_fifo: width ratio must be a power of two no larger than the depth");
      end
   endgenerate

   logic [MIN_W-1:0]    mem [DEPTH];
   logic [ADDR_W-1:0]   wptr;
   logic [ADDR_W-1:0]   rptr;
   logic [ADDR_W:0]     level_q;
   logic [R_DATA_W-1:0] r_data_q;
   logic                w_full;
   logic                r_empty;
   logic                w_acc;
   logic                r_acc;

   // Flags come from the registered level, so a same-cycle write is never visible to the reader.
   assign w_full  = (level_q > FULL_THR);
   assign r_empty = (level_q < R_DEC);
   assign w_acc   = fifo_if.w_en & ~w_full;
   assign r_acc   = fifo_if.r_en & ~r_empty;

   assign fifo_if.w_full  = w_full;
   assign fifo_if.r_empty = r_empty;
   assign fifo_if.level   = level_q;
   assign fifo_if.r_data  = r_data_q;

   // Storage is not reset; reset only discards it by clearing the pointers and level.
   always_ff @(posedge clk) begin
      if (!rst && w_acc) begin
         for (int i = 0; i < W_RATIO; i++) begin
            mem[wptr + ADDR_W'(i)] <= fifo_if.w_data[i*MIN_W +: MIN_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr     <= '0;
         rptr     <= '0;
         level_q  <= '0;
         r_data_q <= '0;
      end else begin
         if (w_acc) begin
            wptr <= wptr + W_STEP;
         end
         if (r_acc) begin
            rptr <= rptr + R_STEP;
            // Lowest slice takes the oldest entry: little-endian packing.
            for (int j = 0; j < R_RATIO; j++) begin
               r_data_q[j*MIN_W +: MIN_W] <= mem[rptr + ADDR_W'(j)];
            end
         end
         level_q <= level_q + (w_acc ? W_INC : '0) - (r_acc ? R_DEC : '0);
      end
   end
endmodule
